// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: programmable clock-enable generator for the 6502 core.
// Issues a registered one-cycle cpu_ce strobe in run mode (every div_sel+1
// cycles), on a debounced single-step press, and halts on an opcode-fetch
// breakpoint.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_HALTED  | CPU frozen, cpu_ce low; waits for run_req or a step event
//   ST_RUNNING | divider active, cpu_ce on every tick not hit by breakpoint
//   ST_STEP    | single cycle with cpu_ce high, then back to ST_HALTED
module cpu_clock_ctrl #(
    parameter int DIV_W      = 17,
    parameter int ADDR_W     = 16,
    parameter int CNT_W      = 32,
    parameter int DEB_CYCLES = 120000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_btn,
    input  logic [DIV_W-1:0]  div_sel,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_fetch,
    output logic              cpu_ce,
    output logic              running,
    output logic              bp_hit,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_HALTED  = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STEP    = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt, div_cnt_nxt;
    logic               cpu_ce_nxt;
    logic               bp_skip, bp_skip_nxt;
    logic               bp_hit_nxt;

    logic [1:0]         step_sync;
    logic [DEB_W-1:0]   deb_cnt;
    logic               deb_level;
    logic               deb_level_d;
    logic               step_evt;

    logic               div_tick;
    logic               bp_match;

    // Two-flop synchroniser for the raw push-button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_sync <= 2'b00;
        end else begin
            step_sync <= {step_sync[0], step_btn};
        end
    end

    // Debouncer: accept a new level only after DEB_CYCLES straight cycles of disagreement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
        end else if (step_sync[1] == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            deb_cnt   <= '0;
            deb_level <= step_sync[1];
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    // Registered rising-edge detect of the debounced level gives a one-cycle step event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_level_d <= 1'b0;
            step_evt    <= 1'b0;
        end else begin
            deb_level_d <= deb_level;
            step_evt    <= deb_level & ~deb_level_d;
        end
    end

    assign div_tick = (div_cnt >= div_sel);
    assign bp_match = bp_en & cpu_fetch & (cpu_addr == bp_addr) & ~bp_skip;

    // Next-state, divider and breakpoint decisions; halt_req overrides everything.
    always_comb begin
        state_nxt   = state;
        div_cnt_nxt = div_cnt;
        cpu_ce_nxt  = 1'b0;
        bp_skip_nxt = bp_skip;
        bp_hit_nxt  = bp_hit;
        if (halt_req) begin
            state_nxt = ST_HALTED;
        end else begin
            case (state)
                ST_HALTED: begin
                    if (run_req) begin
                        state_nxt   = ST_RUNNING;
                        div_cnt_nxt = '0;
                        bp_skip_nxt = 1'b1;
                        bp_hit_nxt  = 1'b0;
                    end else if (step_evt) begin
                        state_nxt  = ST_STEP;
                        cpu_ce_nxt = 1'b1;
                        bp_hit_nxt = 1'b0;
                    end
                end
                ST_RUNNING: begin
                    if (div_tick) begin
                        div_cnt_nxt = '0;
                        if (bp_match) begin
                            state_nxt  = ST_HALTED;
                            bp_hit_nxt = 1'b1;
                        end else begin
                            cpu_ce_nxt  = 1'b1;
                            bp_skip_nxt = 1'b0;
                        end
                    end else begin
                        div_cnt_nxt = div_cnt + DIV_W'(1);
                    end
                end
                ST_STEP: begin
                    state_nxt = ST_HALTED;
                end
                default: begin
                    state_nxt = ST_HALTED;
                end
            endcase
        end
    end

    // Control state register and registered strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_HALTED;
            div_cnt <= '0;
            cpu_ce  <= 1'b0;
            bp_skip <= 1'b0;
            bp_hit  <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_cnt_nxt;
            cpu_ce  <= cpu_ce_nxt;
            bp_skip <= bp_skip_nxt;
            bp_hit  <= bp_hit_nxt;
        end
    end

    // Executed-cycle counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (cpu_ce) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    assign running = (state == ST_RUNNING);

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
- Parametrised CPU clock-enable generator. Replaces the fixed power-of-two `clkdiv` divider in front of the 6502 datapath.
- Produces a one-cycle `cpu_ce` strobe that gates every CPU register and the control FSM.
- Divide ratio is programmable at run time.
- Supports run, halt and debounced single-step modes, plus an opcode-fetch address breakpoint.
- Sits between board clock/buttons and the CPU core, beside the seven-segment pulser.

Parameters:
- DIV_W, 17, width of the programmable divide-select input.
- ADDR_W, 16, width of the breakpoint and CPU address compare.
- CNT_W, 32, width of the executed-CPU-cycle counter.
- DEB_CYCLES, 120000, consecutive stable `clk` cycles required to accept a `step_btn` level change (must be at least 1).

Ports:
- clk  in  1  board clock; all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- run_req  in  1  synchronous single-cycle pulse: start free-running.
- halt_req  in  1  synchronous single-cycle pulse: stop.
- step_btn  in  1  raw asynchronous push-button, active high.
- div_sel  in  DIV_W  in RUNNING, `cpu_ce` fires once every `div_sel`+1 `clk` cycles.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  ADDR_W  breakpoint opcode address.
- cpu_addr  in  ADDR_W  current CPU address ({memory_bus_h, memory_bus_l}).
- cpu_fetch  in  1  high when the current CPU cycle is an opcode fetch.
- cpu_ce  out  1  registered CPU clock-enable strobe.
- running  out  1  high while in RUNNING.
- bp_hit  out  1  sticky: the last halt was caused by the breakpoint.
- cycle_count  out  CNT_W  count of `cpu_ce` pulses issued.

Behaviour:
- Reset (async, immediate) clears: state=HALTED, cpu_ce=0, running=0, bp_hit=0, cycle_count=0, div_cnt=0, bp_skip=0, synchroniser, debounce counter and debounced level. Release is synchronous to `clk`.
- States:
  - HALTED: cpu_ce=0.
  - RUNNING: divider active.
  - STEP: exactly one cycle; cpu_ce=1 in that cycle.
- Transitions, evaluated per `clk` edge, highest priority first:
  - halt_req: go to HALTED from any state; no `cpu_ce` in the following cycle.
  - HALTED with run_req: go to RUNNING; div_cnt=0, bp_skip=1, bp_hit=0.
  - HALTED with step event: go to STEP; bp_hit=0.
  - STEP: return to HALTED unconditionally.
  - RUNNING: run_req and step events are ignored and dropped.
  - Simultaneous run_req and step event in HALTED: run wins; the step event is dropped.
- Divider (RUNNING only):
  - Tick when div_cnt >= div_sel, then div_cnt=0; otherwise div_cnt increments.
  - `>=` makes a mid-count reduction of `div_sel` wrap at once.
  - div_sel=0 gives `cpu_ce` on every cycle.
  - The first `cpu_ce` is high in the (div_sel+1)th cycle after `running` rises.
  - `cpu_ce` is registered: it goes high the cycle after the tick condition and stays high for exactly 1 cycle.
- Breakpoint:
  - A tick with bp_en & cpu_fetch & (cpu_addr==bp_addr) & !bp_skip suppresses that `cpu_ce`, goes to HALTED and sets bp_hit=1.
  - bp_skip clears on the first issued `cpu_ce` after entering RUNNING, so resuming from a breakpoint executes the matching opcode once.
  - STEP never checks the breakpoint.
- cycle_count: +1 on every cycle with cpu_ce=1; wraps modulo 2^CNT_W; cleared only by rst.
- Step input path:
  - step_btn passes through a 2-flop synchroniser.
  - The debounced level takes the synchronised value after DEB_CYCLES consecutive cycles of disagreement; the debounce counter clears whenever the two agree.
  - Step event = debounced 0->1 transition (one cycle).
  - Press-to-`cpu_ce` latency is DEB_CYCLES+4 cycles.
  - Release, and any bounce shorter than DEB_CYCLES, produces no event.
- Reset mid-operation: an in-flight `cpu_ce` drops at once; a half-debounced press is discarded.

Test Plan:
- Assert rst mid-RUNNING with div_sel=0 -> cpu_ce, running, bp_hit and cycle_count go to 0 the same cycle, without waiting for a clk edge.
- div_sel=3, pulse run_req, run 20 cycles -> cpu_ce high on cycles 4, 8, 12, 16, 20 after running rises; cycle_count=5. Change div_sel to 1 at div_cnt=2 -> the next cpu_ce follows immediately, then every 2 cycles.
- In HALTED, pulse run_req and halt_req in the same cycle -> running stays 0 and no cpu_ce. In RUNNING, pulse halt_req -> running=0 next cycle and no further cpu_ce.
- DEB_CYCLES=4, HALTED:
  - 2-cycle step_btn glitch -> no cpu_ce.
  - Hold for 10 cycles -> exactly one cpu_ce at press+8 cycles; cycle_count +1.
  - Hold for 50 cycles -> still one cpu_ce.
- bp_en=1, bp_addr=16'h0203, div_sel=0:
  - Drive cpu_fetch=1 with cpu_addr=16'h0203 while RUNNING -> cpu_ce suppressed, running=0, bp_hit=1.
  - Pulse run_req with the address held -> the first cpu_ce is issued and bp_hit=0.
  - Refetch 16'h0203 later -> halts again.
- In RUNNING, press step_btn and pulse run_req -> both ignored: cpu_ce cadence unchanged and no extra pulse once halted.
